gshare_bpu: RTL and testbench
=============================

GSHARE_BPU -- requirements
Module: gshare_bpu

Interface
REQ-001 SHALL have parameter GHR_BITS, default 8, global history length; the PHT holds 2^GHR_BITS entries.
REQ-002 SHALL have parameter BTB_ENTRIES, default 16, number of direct-mapped BTB entries (power of 2).
REQ-003 SHALL have port i_clk  in  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port i_reset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_if_pc  in  32  fetch PC to predict.
REQ-006 SHALL have port o_pred_taken  out  1  predicted taken, fed to IF/ID and then ID/EX pred_taken.
REQ-007 SHALL have port o_pred_target  out  32  predicted target; only meaningful when o_pred_taken=1.
REQ-008 SHALL have port o_ready  out  1  high once table initialisation completes.
REQ-009 SHALL have port i_ex_valid  in  1  EX-stage instruction valid (from ID/EX o_valid).
REQ-010 SHALL have port i_ex_stall  in  1  EX stage held this cycle; no update is performed.
REQ-011 SHALL have ports i_ex_is_branch and i_ex_is_jal  in  1 each  EX instruction class.
REQ-012 SHALL have ports i_ex_taken (1), i_ex_pred_taken (1), i_ex_pc (32), i_ex_target (32)  in  resolved outcome, carried prediction, EX PC, resolved target.
REQ-013 SHALL have ports o_mispredict (1) and o_redirect_pc (32)  out  flush request and correct PC.
REQ-014 SHALL have ports o_br_count (32) and o_mis_count (32)  out  resolved-branch and mispredict counters.

Function
REQ-015 PHT index SHALL be i_if_pc[GHR_BITS+1:2] XOR GHR for prediction and i_ex_pc[GHR_BITS+1:2] XOR GHR for update, using the current non-speculative GHR.
REQ-016 BTB index SHALL be pc[log2(BTB_ENTRIES)+1:2]; tag SHALL be the remaining pc[31:log2(BTB_ENTRIES)+2]; each entry holds valid, tag, 32-bit target, is_jal flag.
REQ-017 Prediction SHALL be combinational: o_pred_taken = o_ready AND BTB hit AND (entry is_jal OR PHT counter[1]); o_pred_target = BTB target; hit reads return pre-update values (read-before-write).
REQ-018 FSM SHALL have states INIT and RUN; reset enters INIT with index counter 0; INIT writes PHT[i]=2'b01 and clears BTB valid for i<BTB_ENTRIES, one entry per cycle; after entry 2^GHR_BITS-1 it moves to RUN; o_ready=1 only in RUN.
REQ-019 An update SHALL occur when state=RUN, i_ex_valid=1, i_ex_stall=0 and (i_ex_is_branch or i_ex_is_jal); in INIT all updates are dropped.
REQ-020 On branch update PHT counter SHALL increment saturating at 3 if i_ex_taken, else decrement saturating at 0; GHR SHALL shift left, inserting i_ex_taken at bit 0.
REQ-021 JAL updates SHALL not touch PHT or GHR.
REQ-022 On any update with i_ex_taken=1 the BTB entry SHALL be written valid with tag, i_ex_target and is_jal; a not-taken branch SHALL leave the BTB unchanged.
REQ-023 o_mispredict SHALL be combinational: update condition AND (i_ex_taken != i_ex_pred_taken); o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc+4 (mod 2^32).
REQ-024 o_br_count SHALL increment on each branch update; o_mis_count on each cycle o_mispredict=1; both SHALL saturate at 32'hFFFFFFFF.
REQ-025 Prediction and update to the same PHT/BTB entry in one cycle SHALL return the old value for prediction and commit the new value at the edge.

Reset
REQ-026 i_reset=1 at an edge SHALL set state=INIT, init index=0, GHR=0, both counters=0, o_ready=0, irrespective of current state, including mid-INIT.
REQ-027 During reset and INIT, o_pred_taken and o_mispredict SHALL be 0.

Verification
REQ-028 Reset then idle: o_ready rises exactly 256 cycles after i_reset deasserts (GHR_BITS=8); o_pred_taken=0 throughout.
REQ-029 Branch at pc 0x100, target 0x80, taken twice -> after first update BTB hit, counter 2 (with GHR 0x00 index), GHR=0x01; o_pred_taken=1 on pc 0x100 once GHR index again matches a counter>=2.
REQ-030 Counter saturation: five taken updates on one index -> counter stays 3; five not-taken -> stays 0, o_pred_taken=0 on hit.
REQ-031 JAL at pc 0x40 target 0x200, i_ex_pred_taken=0 -> o_mispredict=1, o_redirect_pc=0x200, GHR unchanged; next fetch of 0x40 -> o_pred_taken=1, o_pred_target=0x200.
REQ-032 Not-taken branch at pc 0xFFFFFFFC with i_ex_pred_taken=1 -> o_mispredict=1, o_redirect_pc=0x00000000, o_mis_count+1.
REQ-033 i_ex_stall=1 or i_reset mid-INIT with valid branch inputs -> no PHT/GHR/counter change; INIT restarts at index 0.

Source files
------------

// File: rtl/gshare_bpu.sv
// Gshare branch predictor with a direct-mapped BTB, table initialisation FSM,
// EX-stage resolution/update path and resolved-branch / mispredict counters.
module gshare_bpu #(
    parameter int GHR_BITS    = 8,
    parameter int BTB_ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    output logic        o_ready,
    input  logic        i_ex_valid,
    input  logic        i_ex_stall,
    input  logic        i_ex_is_branch,
    input  logic        i_ex_is_jal,
    input  logic        i_ex_taken,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_target,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mis_count,
    output logic        o_dbg_state
);

    localparam int PHT_ENTRIES  = 1 << GHR_BITS;
    localparam int BTB_IDX_BITS = $clog2(BTB_ENTRIES);
    localparam int TAG_BITS     = 30 - BTB_IDX_BITS;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [GHR_BITS-1:0] init_idx_q, init_idx_d;
    logic                init_we;
    logic [GHR_BITS-1:0] ghr_q;

    logic [1:0]          pht        [PHT_ENTRIES];
    logic                btb_valid  [BTB_ENTRIES];
    logic [TAG_BITS-1:0] btb_tag    [BTB_ENTRIES];
    logic [31:0]         btb_target [BTB_ENTRIES];
    logic                btb_jal    [BTB_ENTRIES];

    logic [BTB_IDX_BITS-1:0] if_btb_idx, ex_btb_idx;
    logic [GHR_BITS-1:0]     if_pht_idx, ex_pht_idx;
    logic                    if_hit;
    logic [1:0]              if_ctr, ex_ctr, ex_ctr_next;
    logic                    upd, br_upd;

    assign o_dbg_state = state_q;
    assign o_ready     = (state_q == ST_RUN);

    // Prediction path: combinational table reads, old contents win on a same-cycle update.
    assign if_btb_idx    = i_if_pc[BTB_IDX_BITS+1:2];
    assign if_pht_idx    = i_if_pc[GHR_BITS+1:2] ^ ghr_q;
    assign if_hit        = btb_valid[if_btb_idx] && (btb_tag[if_btb_idx] == i_if_pc[31:BTB_IDX_BITS+2]);
    assign if_ctr        = pht[if_pht_idx];
    assign o_pred_taken  = o_ready && !i_reset && if_hit && (btb_jal[if_btb_idx] || if_ctr[1]);
    assign o_pred_target = btb_target[if_btb_idx];

    // An EX instruction is consumed when valid and not stalled; there is no
    // back-pressure toward EX, so stall simply means "hold, do not update".
    assign upd    = o_ready && !i_reset && i_ex_valid && !i_ex_stall && (i_ex_is_branch || i_ex_is_jal);
    assign br_upd = upd && i_ex_is_branch;

    assign ex_btb_idx = i_ex_pc[BTB_IDX_BITS+1:2];
    assign ex_pht_idx = i_ex_pc[GHR_BITS+1:2] ^ ghr_q;
    assign ex_ctr     = pht[ex_pht_idx];

    always_comb begin
        ex_ctr_next = ex_ctr;
        if (i_ex_taken) begin
            if (ex_ctr != 2'b11) ex_ctr_next = ex_ctr + 2'b01;
        end else begin
            if (ex_ctr != 2'b00) ex_ctr_next = ex_ctr - 2'b01;
        end
    end

    assign o_mispredict  = upd && (i_ex_taken != i_ex_pred_taken);
    assign o_redirect_pc = i_ex_taken ? i_ex_target : (i_ex_pc + 32'd4);

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        init_we    = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we    = 1'b1;
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == '1) state_d = ST_RUN;
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_INIT;
            init_idx_q  <= '0;
            ghr_q       <= '0;
            o_br_count  <= '0;
            o_mis_count <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            if (br_upd) begin
                ghr_q <= {ghr_q[GHR_BITS-2:0], i_ex_taken};
                if (o_br_count != 32'hFFFF_FFFF) o_br_count <= o_br_count + 32'd1;
            end
            if (o_mispredict && (o_mis_count != 32'hFFFF_FFFF)) o_mis_count <= o_mis_count + 32'd1;
        end
    end

    // Tables carry no reset; the INIT sweep gives them defined contents before RUN.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (init_we) begin
                pht[init_idx_q] <= 2'b01;
                if (int'(init_idx_q) < BTB_ENTRIES) btb_valid[init_idx_q[BTB_IDX_BITS-1:0]] <= 1'b0;
            end
            if (br_upd) pht[ex_pht_idx] <= ex_ctr_next;
            if (upd && i_ex_taken) begin
                btb_valid[ex_btb_idx]  <= 1'b1;
                btb_tag[ex_btb_idx]    <= i_ex_pc[31:BTB_IDX_BITS+2];
                btb_target[ex_btb_idx] <= i_ex_target;
                btb_jal[ex_btb_idx]    <= i_ex_is_jal;
            end
        end
    end

endmodule

// File: tb/tb_gshare_bpu.sv
// Bench for gshare_bpu: directed scenarios with literal expectations, then random
// traffic checked every cycle against an array-based behavioural model.
module tb_gshare_bpu;

  localparam int PHT_N       = 256;
  localparam int BTB_N       = 16;
  localparam int INIT_CYCLES = 256;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_if_pc;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        o_ready;
  logic        i_ex_valid, i_ex_stall, i_ex_is_branch, i_ex_is_jal, i_ex_taken, i_ex_pred_taken;
  logic [31:0] i_ex_pc, i_ex_target;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc, o_br_count, o_mis_count;
  logic        o_dbg_state;

  always #5 clk = ~clk;

  gshare_bpu #(.GHR_BITS(8), .BTB_ENTRIES(16)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_if_pc(i_if_pc),
    .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target), .o_ready(o_ready),
    .i_ex_valid(i_ex_valid), .i_ex_stall(i_ex_stall),
    .i_ex_is_branch(i_ex_is_branch), .i_ex_is_jal(i_ex_is_jal),
    .i_ex_taken(i_ex_taken), .i_ex_pred_taken(i_ex_pred_taken),
    .i_ex_pc(i_ex_pc), .i_ex_target(i_ex_target),
    .o_mispredict(o_mispredict), .o_redirect_pc(o_redirect_pc),
    .o_br_count(o_br_count), .o_mis_count(o_mis_count), .o_dbg_state(o_dbg_state)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: plain arrays indexed with integer arithmetic.
  int          m_pht [PHT_N];
  bit          m_bv  [BTB_N];
  logic [31:0] m_btag[BTB_N];
  logic [31:0] m_bt  [BTB_N];
  bit          m_bj  [BTB_N];
  int          m_ghr;
  int          m_since_reset;
  bit          m_known = 0;
  bit          m_ready = 0;
  logic [31:0] m_br, m_misc;
  logic [63:0] exp_q[$];

  // Inputs change at posedge+1; the model judges the outputs at negedge,
  // then advances itself to the state that the coming posedge produces.
  always @(negedge clk) begin : cmp_proc
    int bi, pi, ebi, epi;
    bit hit, exp_pt, upd, exp_mp;
    logic [63:0] cnts;
    bi  = int'((i_if_pc >> 2) % BTB_N);
    pi  = int'((i_if_pc >> 2) % PHT_N) ^ m_ghr;
    ebi = int'((i_ex_pc >> 2) % BTB_N);
    epi = int'((i_ex_pc >> 2) % PHT_N) ^ m_ghr;
    hit    = m_bv[bi] && (m_btag[bi] == (i_if_pc >> 6));
    exp_pt = m_ready && !i_reset && hit && (m_bj[bi] || m_pht[pi] >= 2);
    upd    = m_ready && !i_reset && i_ex_valid && !i_ex_stall && (i_ex_is_branch || i_ex_is_jal);
    exp_mp = upd && (i_ex_taken != i_ex_pred_taken);
    if (m_known) begin
      check("ready", o_ready, m_ready);
      check("dbg_state", o_dbg_state, m_ready);
      check("pred_taken", o_pred_taken, exp_pt);
      if (exp_pt) check("pred_target", o_pred_target, m_bt[bi]);
      check("mispredict", o_mispredict, exp_mp);
      if (exp_mp) check("redirect_pc", o_redirect_pc, i_ex_taken ? i_ex_target : i_ex_pc + 32'd4);
      if (exp_q.size() > 0) begin
        cnts = exp_q.pop_front();
        check("br_count", o_br_count, cnts[63:32]);
        check("mis_count", o_mis_count, cnts[31:0]);
      end
    end
    if (i_reset) begin
      m_known = 1; m_ready = 0; m_since_reset = 0; m_ghr = 0; m_br = 0; m_misc = 0;
    end else if (m_known) begin
      if (!m_ready) begin
        m_since_reset++;
        if (m_since_reset == INIT_CYCLES) begin
          m_ready = 1;
          foreach (m_pht[k]) m_pht[k] = 1;
          foreach (m_bv[k]) m_bv[k] = 0;
        end
      end else if (upd) begin
        if (i_ex_is_branch) begin
          m_pht[epi] = i_ex_taken ? ((m_pht[epi] < 3) ? m_pht[epi] + 1 : 3)
                                  : ((m_pht[epi] > 0) ? m_pht[epi] - 1 : 0);
          m_ghr = ((m_ghr << 1) | int'(i_ex_taken)) % PHT_N;
          if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
        end
        if (i_ex_taken) begin
          m_bv[ebi] = 1; m_btag[ebi] = i_ex_pc >> 6; m_bt[ebi] = i_ex_target; m_bj[ebi] = i_ex_is_jal;
        end
        if (exp_mp && m_misc != 32'hFFFF_FFFF) m_misc = m_misc + 1;
      end
    end
    if (m_known) exp_q.push_back({m_br, m_misc});
  end

  function automatic logic [31:0] pick_pc();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return 32'h0000_0100;
      1: return 32'h0000_0040;
      2: return 32'hFFFF_FFFC;
      3: return 32'h1000 + 32'($urandom_range(0, 63)) * 4;
      4: return 32'h0000_0080;
      default: return r & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    i_ex_valid = 0; i_ex_stall = 0; i_ex_is_branch = 0; i_ex_is_jal = 0;
    i_ex_taken = 0; i_ex_pred_taken = 0; i_ex_pc = 0; i_ex_target = 0;
  endtask

  task automatic set_ex(input bit br, input bit jal, input bit taken, input bit pred,
                        input logic [31:0] pc, input logic [31:0] tgt);
    i_ex_valid = 1; i_ex_stall = 0; i_ex_is_branch = br; i_ex_is_jal = jal;
    i_ex_taken = taken; i_ex_pred_taken = pred; i_ex_pc = pc; i_ex_target = tgt;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (!o_ready && lat < 400) begin
      i_if_pc = pick_pc();
      step();
      lat++;
    end
  endtask

  task automatic rand_cycle();
    int cls;
    cls = $urandom_range(0, 3);
    i_if_pc         = pick_pc();
    i_ex_valid      = ($urandom_range(0, 3) != 0);
    i_ex_stall      = ($urandom_range(0, 5) == 0);
    i_ex_is_branch  = (cls == 1 || cls == 2);
    i_ex_is_jal     = (cls == 3);
    i_ex_taken      = (cls == 3) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
    i_ex_pred_taken = 1'($urandom_range(0, 1));
    i_ex_pc         = pick_pc();
    i_ex_target     = pick_pc();
    i_reset         = ($urandom_range(0, 599) == 0);
    step();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    clear_ex();
    i_if_pc = 0;
    i_reset = 1;
    repeat (3) step();
    i_reset = 0;
    wait_ready(lat);
    check("ready_latency", lat, 256);

    // First taken branch: index 0x40 with GHR 0 goes 1->2, GHR becomes 0x01.
    set_ex(1, 0, 1, 0, 32'h100, 32'h80);
    #1;
    check("br_mispredict", o_mispredict, 1);
    check("br_redirect", o_redirect_pc, 32'h80);
    step();
    clear_ex();
    i_if_pc = 32'h100;
    #1;
    check("br_pred_after_one", o_pred_taken, 0);

    // Taken run: GHR saturates to 0xFF, index 0xBF climbs to 3.
    for (int i = 0; i < 13; i++) begin
      set_ex(1, 0, 1, 1, 32'h100, 32'h80);
      step();
    end
    clear_ex();
    i_if_pc = 32'h100;
    #1;
    check("sat_high_pred", o_pred_taken, 1);
    check("sat_high_target", o_pred_target, 32'h80);

    // Not-taken run: GHR drains to 0, index 0x40 falls to 0.
    for (int i = 0; i < 13; i++) begin
      set_ex(1, 0, 0, 0, 32'h100, 32'h80);
      step();
    end
    clear_ex();
    i_if_pc = 32'h100;
    #1;
    check("sat_low_pred", o_pred_taken, 0);
    check("br_count_27", o_br_count, 27);
    check("mis_count_1", o_mis_count, 1);

    // JAL shares BTB slot 0 with 0x100; same-cycle fetch sees the old entry.
    set_ex(0, 1, 1, 0, 32'h40, 32'h200);
    i_if_pc = 32'h40;
    #1;
    check("jal_mispredict", o_mispredict, 1);
    check("jal_redirect", o_redirect_pc, 32'h200);
    check("jal_same_cycle_pred", o_pred_taken, 0);
    step();
    clear_ex();
    #1;
    check("jal_pred", o_pred_taken, 1);
    check("jal_target", o_pred_target, 32'h200);

    set_ex(1, 0, 0, 1, 32'hFFFF_FFFC, 32'h1234_5678);
    #1;
    check("wrap_mispredict", o_mispredict, 1);
    check("wrap_redirect", o_redirect_pc, 32'h0);
    step();
    clear_ex();
    check("mis_count_3", o_mis_count, 3);
    check("br_count_28", o_br_count, 28);

    set_ex(1, 0, 1, 0, 32'h100, 32'h80);
    i_ex_stall = 1;
    #1;
    check("stall_mispredict", o_mispredict, 0);
    step();
    clear_ex();
    check("stall_br_count", o_br_count, 28);
    check("stall_mis_count", o_mis_count, 3);

    // Reset mid-INIT with a live branch on the EX inputs.
    i_reset = 1;
    step();
    i_reset = 0;
    repeat (100) step();
    set_ex(1, 0, 1, 0, 32'h100, 32'h80);
    i_reset = 1;
    step();
    i_reset = 0;
    wait_ready(lat);
    clear_ex();
    check("reinit_latency", lat, 256);
    check("reinit_br_count", o_br_count, 0);
    check("reinit_mis_count", o_mis_count, 0);

    for (int i = 0; i < 4000; i++) rand_cycle();

    i_reset = 0;
    clear_ex();
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
